// File: rtl/nec_ir_frame_decoder_tol.sv
// ============================================================================
// Module   : nec_ir_frame_decoder_tol
// Purpose  : NEC IR frame decoder that matches symbols to unit multiples +/- tolerance.
//            Define NEC_IR_DEC_REPEAT_CNT_EN to add the saturating repeat_count output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module nec_ir_frame_decoder_tol #(
  parameter int DBITS = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             receiver_en,
  input  logic             repeat_en,
  input  logic             ext_addr,
  input  logic [DBITS-1:0] t_unit,
  input  logic [DBITS-1:0] t_tol,
  input  logic             event_new,
  input  logic             event_type,
  input  logic [DBITS-1:0] event_delay,
  input  logic             event_timeout,
  output logic [15:0]      frame_addr,
  output logic [7:0]       frame_data,
  output logic             frame_repeat,
  output logic             frame_write,
  output logic             frame_error,
  output logic [2:0]       error_code
`ifdef NEC_IR_DEC_REPEAT_CNT_EN
  ,
  output logic [7:0]       repeat_count
`endif
);

  localparam int c_XW = DBITS + 5;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEAD   = 3'd1,
    S_PREFIX = 3'd2,
    S_LATCH  = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_shift, w_shift_nxt;
  logic [5:0]  r_cnt, w_cnt_nxt;
  logic        r_armed, w_armed_nxt;
  logic        r_rpt, w_rpt_nxt;
  logic        w_wr, w_err, w_bit;
  logic [2:0]  w_code;
  logic [15:0] w_addr;
  logic        w_m1, w_m3, w_m4, w_m8, w_m16;

  // Lower window edge saturates at zero; widened arithmetic cannot overflow.
  function automatic logic f_match(input logic [4:0] k, input logic [DBITS-1:0] unit,
                                   input logic [DBITS-1:0] tol, input logic [DBITS-1:0] dly);
    logic [c_XW-1:0] nom, lo, hi, d;
    nom = c_XW'(k) * c_XW'(unit);
    lo  = (nom > c_XW'(tol)) ? (nom - c_XW'(tol)) : '0;
    hi  = nom + c_XW'(tol);
    d   = c_XW'(dly);
    return (d >= lo) && (d <= hi);
  endfunction

  assign w_m1  = !event_timeout && f_match(5'd1,  t_unit, t_tol, event_delay);
  assign w_m3  = !event_timeout && f_match(5'd3,  t_unit, t_tol, event_delay);
  assign w_m4  = !event_timeout && f_match(5'd4,  t_unit, t_tol, event_delay);
  assign w_m8  = !event_timeout && f_match(5'd8,  t_unit, t_tol, event_delay);
  assign w_m16 = !event_timeout && f_match(5'd16, t_unit, t_tol, event_delay);

  assign w_addr = ext_addr ? r_shift[15:0] : {8'h00, r_shift[7:0]};

  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_cnt_nxt   = r_cnt;
    w_armed_nxt = r_armed;
    w_rpt_nxt   = r_rpt;
    w_wr        = 1'b0;
    w_err       = 1'b0;
    w_code      = 3'd0;
    w_bit       = 1'b0;
    if (event_new) begin
      if (r_state != S_IDLE && event_timeout) begin
        w_err  = 1'b1;
        w_code = 3'd7;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (event_timeout)
              w_armed_nxt = 1'b0;
            else if (!event_type && w_m16)
              w_state_nxt = S_LEAD;
          end
          S_LEAD: begin
            if (event_type && w_m8) begin
              w_state_nxt = S_PREFIX;
              w_shift_nxt = '0;
              w_cnt_nxt   = '0;
              w_rpt_nxt   = 1'b0;
            end else if (repeat_en && event_type && w_m4 && r_armed) begin
              w_state_nxt = S_STOP;
              w_rpt_nxt   = 1'b1;
            end else begin
              w_err  = 1'b1;
              w_code = 3'd1;
            end
          end
          S_PREFIX: begin
            if (!event_type && w_m1) begin
              w_state_nxt = S_LATCH;
            end else begin
              w_err  = 1'b1;
              w_code = 3'd2;
            end
          end
          S_LATCH: begin
            if (event_type && (w_m1 || w_m3)) begin
              w_bit       = !w_m1;
              w_shift_nxt = {w_bit, r_shift[31:1]};
              w_cnt_nxt   = r_cnt + 6'd1;
              w_state_nxt = (w_cnt_nxt == 6'd32) ? S_STOP : S_PREFIX;
            end else begin
              w_err  = 1'b1;
              w_code = 3'd3;
            end
          end
          S_STOP: begin
            w_state_nxt = S_IDLE;
            if (event_type || !w_m1) begin
              w_err  = 1'b1;
              w_code = 3'd4;
            end else if (r_rpt) begin
              w_wr = 1'b1;
            end else if (!ext_addr && (r_shift[7:0] != ~r_shift[15:8])) begin
              w_err  = 1'b1;
              w_code = 3'd5;
            end else if (r_shift[23:16] != ~r_shift[31:24]) begin
              w_err  = 1'b1;
              w_code = 3'd6;
            end else begin
              w_wr = 1'b1;
            end
          end
          default: w_state_nxt = S_IDLE;
        endcase
      end
      if (w_err) begin
        w_state_nxt = S_IDLE;
        w_armed_nxt = 1'b0;
      end
      if (w_wr && !r_rpt)
        w_armed_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_shift      <= '0;
      r_cnt        <= '0;
      r_armed      <= 1'b0;
      r_rpt        <= 1'b0;
      frame_addr   <= '0;
      frame_data   <= '0;
      frame_repeat <= 1'b0;
      frame_write  <= 1'b0;
      frame_error  <= 1'b0;
      error_code   <= '0;
    end else if (!receiver_en) begin
      r_state     <= S_IDLE;
      r_shift     <= '0;
      r_cnt       <= '0;
      r_armed     <= 1'b0;
      r_rpt       <= 1'b0;
      frame_write <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_shift     <= w_shift_nxt;
      r_cnt       <= w_cnt_nxt;
      r_armed     <= w_armed_nxt;
      r_rpt       <= w_rpt_nxt;
      frame_write <= w_wr;
      frame_error <= w_err;
      if (w_err)
        error_code <= w_code;
      if (w_wr) begin
        frame_repeat <= r_rpt;
        // A repeat re-announces the previous frame, so address/data hold.
        if (!r_rpt) begin
          frame_addr <= w_addr;
          frame_data <= r_shift[23:16];
        end
      end
    end
  end

`ifdef NEC_IR_DEC_REPEAT_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      repeat_count <= '0;
    else if (!receiver_en)
      repeat_count <= '0;
    else if (w_wr) begin
      if (!r_rpt)
        repeat_count <= '0;
      else if (repeat_count != 8'hFF)
        repeat_count <= repeat_count + 8'd1;
    end
  end
`else
`endif

endmodule

`default_nettype wire

// File: tb/tb_nec_ir_frame_decoder_tol.sv
// ============================================================================
// Module   : tb_nec_ir_frame_decoder_tol
// Purpose  : Self-checking bench for nec_ir_frame_decoder_tol against a frame-level model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_nec_ir_frame_decoder_tol;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        receiver_en = 1'b1;
  logic        repeat_en = 1'b0;
  logic        ext_addr = 1'b0;
  logic [31:0] t_unit = 32'd100;
  logic [31:0] t_tol = 32'd10;
  logic        event_new = 1'b0;
  logic        event_type = 1'b0;
  logic [31:0] event_delay = '0;
  logic        event_timeout = 1'b0;
  logic [15:0] frame_addr;
  logic [7:0]  frame_data;
  logic        frame_repeat;
  logic        frame_write;
  logic        frame_error;
  logic [2:0]  error_code;
`ifdef NEC_IR_DEC_REPEAT_CNT_EN
  logic [7:0]  repeat_count;
`endif

  nec_ir_frame_decoder_tol #(.DBITS(32)) dut (
    .clk(clk), .rst_n(rst_n), .receiver_en(receiver_en), .repeat_en(repeat_en),
    .ext_addr(ext_addr), .t_unit(t_unit), .t_tol(t_tol), .event_new(event_new),
    .event_type(event_type), .event_delay(event_delay), .event_timeout(event_timeout),
    .frame_addr(frame_addr), .frame_data(frame_data), .frame_repeat(frame_repeat),
    .frame_write(frame_write), .frame_error(frame_error), .error_code(error_code)
`ifdef NEC_IR_DEC_REPEAT_CNT_EN
    , .repeat_count(repeat_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int n_wr = 0, n_err = 0, n_both = 0;
  logic       m_rpt = 1'b0;
  logic [2:0] m_code = '0;

  always @(negedge clk) begin
    if (frame_write) begin
      n_wr++;
      m_rpt = frame_repeat;
    end
    if (frame_error) begin
      n_err++;
      m_code = error_code;
    end
    if (frame_write && frame_error) n_both++;
  end

  // Frame-level reference state
  logic        mdl_armed = 1'b0;
  logic [15:0] mdl_addr = '0;
  logic [7:0]  mdl_data = '0;
  int          mdl_rc = 0;
  int          b_wr, b_err, b_both;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int jit(input int nom);
    return nom + int'($urandom_range(18, 0)) - 9;
  endfunction

  task automatic ev(input logic t, input int d, input logic to = 1'b0);
    event_new = 1'b1; event_type = t; event_delay = d; event_timeout = to;
    @(negedge clk);
  endtask

  task automatic quiet(input int n);
    event_new = 1'b0; event_timeout = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic mark();
    b_wr = n_wr; b_err = n_err; b_both = n_both;
  endtask

  task automatic send_bits(input logic [31:0] w, input int from, input int upto);
    for (int i = from; i < upto; i++) begin
      ev(1'b0, jit(100));
      ev(1'b1, w[i] ? jit(300) : jit(100));
    end
  endtask

  task automatic send_frame(input logic [31:0] w);
    ev(1'b0, jit(1600));
    ev(1'b1, jit(800));
    send_bits(w, 0, 32);
    ev(1'b0, jit(100));
  endtask

  // code 0 = write expected; rpt selects a repeat write
  task automatic expect_result(input string tag, input int code, input logic rpt);
    quiet(3);
    chk({tag, "_both"}, n_both - b_both, 0);
    if (code == 0) begin
      chk({tag, "_wr"}, n_wr - b_wr, 1);
      chk({tag, "_err"}, n_err - b_err, 0);
      chk({tag, "_rpt"}, m_rpt, rpt);
      chk({tag, "_addr"}, frame_addr, mdl_addr);
      chk({tag, "_data"}, frame_data, mdl_data);
`ifdef NEC_IR_DEC_REPEAT_CNT_EN
      chk({tag, "_rcnt"}, repeat_count, mdl_rc);
`endif
    end else begin
      chk({tag, "_wr"}, n_wr - b_wr, 0);
      chk({tag, "_err"}, n_err - b_err, 1);
      chk({tag, "_code"}, m_code, code);
    end
  endtask

  // Model of a full frame: bytes in transmit order a0,a1,d0,d1
  task automatic frame_test(input string tag, input logic [7:0] a0, input logic [7:0] a1,
                            input logic [7:0] d0, input logic [7:0] d1, input logic ext);
    int code;
    ext_addr = ext;
    if (!ext && (a1 != ~a0)) code = 5;
    else if (d1 != ~d0) code = 6;
    else code = 0;
    mark();
    send_frame({d1, d0, a1, a0});
    if (code == 0) begin
      mdl_addr = ext ? {a1, a0} : {8'h00, a0};
      mdl_data = d0;
      mdl_armed = 1'b1;
      mdl_rc = 0;
    end else begin
      mdl_armed = 1'b0;
    end
    expect_result(tag, code, 1'b0);
  endtask

  task automatic repeat_test(input string tag);
    int code;
    code = (repeat_en && mdl_armed) ? 0 : 1;
    mark();
    ev(1'b0, 1600);
    ev(1'b1, 400);
    ev(1'b0, 100);
    if (code == 0) mdl_rc = (mdl_rc < 255) ? mdl_rc + 1 : 255;
    else mdl_armed = 1'b0;
    expect_result(tag, code, 1'b1);
  endtask

  initial begin
    logic [7:0] a0, a1, d0, d1;
    repeat (3) @(negedge clk);
    chk("rst_addr", frame_addr, 0);
    chk("rst_data", frame_data, 0);
    chk("rst_wr", frame_write, 0);
    chk("rst_err", frame_error, 0);
    chk("rst_code", error_code, 0);
    chk("rst_rpt", frame_repeat, 0);
    rst_n = 1'b1;
    quiet(2);

    frame_test("basic", 8'h5A, 8'hA5, 8'h3C, 8'hC3, 1'b0);

    repeat_en = 1'b1;
    repeat_test("rpt1");
    repeat_test("rpt2");

    mark();
    ev(1'b1, 9999, 1'b1);
    mdl_armed = 1'b0;
    quiet(2);
    repeat_test("rpt_after_to");

    // bad bit length at bit 5
    mark();
    ev(1'b0, 1600); ev(1'b1, 800);
    send_bits(32'hFFFF_0000, 0, 5);
    ev(1'b0, 100); ev(1'b1, 200);
    mdl_armed = 1'b0;
    expect_result("bit5", 3, 1'b0);
    frame_test("recover", 8'h11, 8'hEE, 8'h22, 8'hDD, 1'b0);

    frame_test("ext1", 8'h12, 8'h34, 8'h56, 8'hA9, 1'b1);
    frame_test("ext0_bad", 8'h12, 8'h34, 8'h56, 8'hA9, 1'b0);
    frame_test("data_bad", 8'h12, 8'hED, 8'h56, 8'h57, 1'b0);

    // timeout mid-frame
    mark();
    ev(1'b0, 1600); ev(1'b1, 800);
    send_bits(32'h0F0F_0F0F, 0, 10);
    ev(1'b0, 100, 1'b1);
    mdl_armed = 1'b0;
    expect_result("tmo", 7, 1'b0);

    mark();
    ev(1'b0, 1600); ev(1'b1, 900);
    expect_result("lead", 1, 1'b0);

    for (int k = 0; k < 6; k++) begin
      a0 = 8'($urandom); d0 = 8'($urandom);
      a1 = ($urandom_range(3, 0) == 0) ? 8'($urandom) : ~a0;
      d1 = ($urandom_range(3, 0) == 0) ? 8'($urandom) : ~d0;
      frame_test("rand", a0, a1, d0, d1, 1'($urandom));
      if (mdl_armed && $urandom_range(1, 0) == 1) repeat_test("rand_rpt");
    end

    // receiver disabled mid-frame, then remaining events arrive
    ext_addr = 1'b0;
    mark();
    ev(1'b0, 1600); ev(1'b1, 800);
    send_bits(32'h3CC3_A55A, 0, 20);
    quiet(1);
    receiver_en = 1'b0;
    quiet(3);
    receiver_en = 1'b1;
    mdl_armed = 1'b0;
    mdl_rc = 0;
    send_bits(32'h3CC3_A55A, 20, 32);
    ev(1'b0, 100);
    quiet(3);
    chk("ren_wr", n_wr - b_wr, 0);
    chk("ren_err", n_err - b_err, 0);
    chk("ren_addr", frame_addr, mdl_addr);
    chk("ren_data", frame_data, mdl_data);
    frame_test("fresh", 8'h77, 8'h88, 8'h99, 8'h66, 1'b0);

    // asynchronous reset mid-frame
    mark();
    ev(1'b0, 1600); ev(1'b1, 800);
    send_bits(32'h0, 0, 4);
    event_new = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_addr", frame_addr, 0);
    chk("arst_data", frame_data, 0);
    chk("arst_code", error_code, 0);
    chk("arst_rpt", frame_repeat, 0);
    @(negedge clk);
    rst_n = 1'b1;
    quiet(3);
    chk("arst_wr", n_wr - b_wr, 0);
    chk("arst_err", n_err - b_err, 0);
    mdl_armed = 1'b0;
    mdl_rc = 0;
    frame_test("post_rst", 8'h01, 8'hFE, 8'h80, 8'h7F, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
